alsu_acc_sequencer: RTL and testbench
=====================================

Name: alsu_acc_sequencer

Overview:
Accumulator/sequencer stage wrapped around the 4-bit arithmetic-logic-shift unit.
- Accepts one micro-operation command per handshake and drives the ALSU select, carry-in and operand lines.
- Writes the ALSU result back into an accumulator register AC, and the ALSU carry into flag E.
- Repeats the operation N times, for multi-bit shifts and repeated add, then returns AC/E over a response handshake.
- The ALSU stays external and combinational; this block owns all state.

Parameters:
WIDTH, 4, datapath width of AC, operand and ALSU ports
CNT_W, 3, width of repeat field; iterations = cmd_rep+1 (1..8)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept command
cmd_sel  in  4  {s3,s2,s1,s0} ALSU select
cmd_cin  in  1  ALSU carry-in
cmd_b  in  WIDTH  operand for ALSU b, or load value
cmd_rep  in  CNT_W  repeat count minus one
cmd_load  in  1  1: AC<=cmd_b directly, no ALSU op
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_ac  out  WIDTH  AC value
rsp_e  out  1  E flag
alsu_a  out  WIDTH  AC, to ALSU a
alsu_b  out  WIDTH  latched operand, to ALSU b
alsu_s  out  4  latched select {s3,s2,s1,s0}
alsu_cin  out  1  latched carry-in
alsu_f  in  WIDTH  ALSU result
alsu_carry  in  1  ALSU carry-out

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; AC=0, E=0.
  - Operand, select, cin and iteration registers =0.
  - rsp_valid=0; all alsu_* outputs =0.
- Reset mid-operation aborts immediately; no response is produced.
- FSM states: IDLE, EXEC, DONE.
- cmd_ready = (state==IDLE) && !rst.
- rsp_valid = (state==DONE).
- rsp_ac = AC and rsp_e = E at all times; both are stable while rsp_valid=1.
- IDLE: on cmd_valid&&cmd_ready, latch sel/cin/b, set iter=cmd_rep.
  - cmd_load=1: AC<=cmd_b, E unchanged, next=DONE.
  - Otherwise next=EXEC.
- EXEC: every cycle AC<=alsu_f.
  - If sel[3:2]==00 (arithmetic): E<=alsu_carry. Logic and shift ops leave E unchanged.
  - If iter==0: next=DONE. Else iter<=iter-1.
- DONE: hold outputs; on rsp_ready, next=IDLE.
- Latency from accept to rsp_valid: load = 1 cycle; op = cmd_rep+2 cycles.
- Throughput: one command per (latency+1) cycles minimum; IDLE always lasts at least one cycle.
- cmd_valid during EXEC/DONE is ignored; it must be held by the sender until accepted.
- rsp_ready and cmd_valid in the same DONE cycle: the response completes; the command is accepted in the following IDLE cycle.
- Arithmetic wraps modulo 2^WIDTH; carry-out goes only to E.
- Shift ops shift AC (alsu_a) with zero fill; alsu_b is don't-care for them.
- alsu_* outputs change only on command accept and AC update; they are registered, with no combinational path from cmd_* to alsu_*.
- ALSU select encoding:
  - sel[3:2]: 00 = arithmetic (b + {a, ~a, 0, all-ones}[s1s0], +cin); 01 = logic (AND, OR, XOR, NOT on s1s0 = 00, 10, 01, 11); 10 = shr a; 11 = shl a.
  - The sequencer treats sel as opaque except for the sel[3:2]==00 test.

Optional Feature:
ALSU_ACC_ZFLAG_EN
- Defined: adds output rsp_z (1 bit), a registered flag updated with every AC write.
  - rsp_z = (new AC == 0); reset value 1.
  - Also updated on load.
- Undefined: port absent; no zero-detect logic.

Decomposition:
- Package alsu_pkg:
  - State enum (IDLE/EXEC/DONE).
  - Select-field constants ALSU_GRP_ARITH=2'b00, ALSU_GRP_LOGIC=2'b01, ALSU_GRP_SHR=2'b10, ALSU_GRP_SHL=2'b11.
  - Default WIDTH/CNT_W.
- One sub-module, alsu_acc_ctrl: FSM plus iteration counter, producing ac_we/e_we/accept strobes.
- Datapath registers stay in the top.

Test Plan:
- Reset during EXEC of a rep=7 shl op -> AC=0, E=0, rsp_valid=0, cmd_ready=1 after release; no response is issued.
- Load cmd_b=0101 -> rsp_valid 1 cycle after accept, rsp_ac=0101, rsp_e=0.
- With AC=0101: sel=0000, b=0011, cin=0, rep=1 -> AC steps 1000 then 1011; rsp_ac=1011, rsp_e=0, rsp_valid at accept+3.
- With AC=1111: sel=0000, b=0001, rep=0 -> rsp_ac=0000, rsp_e=1. Then sel=0100 (AND), b=1010 -> rsp_ac=0000, rsp_e stays 1.
- With AC=0101: sel=1100 (shl), rep=2 -> AC 1010, 0100, 1000; rsp_ac=1000. Then sel=1000 (shr), rep=3 -> rsp_ac=0000.
- Backpressure: hold rsp_ready=0 for 5 cycles with cmd_valid=1 -> rsp_ac stable, cmd_ready=0 throughout; the command is accepted exactly 1 cycle after rsp_ready.

Source files
------------

// File: rtl/alsu_pkg.sv
// Shared types and constants for the ALSU accumulator/sequencer.
// Optional zero flag output is enabled by defining ALSU_ACC_ZFLAG_EN.
package alsu_pkg;

    localparam int ALSU_WIDTH_DEF = 4;
    localparam int ALSU_CNT_W_DEF = 3;

    localparam logic [1:0] ALSU_GRP_ARITH = 2'b00;
    localparam logic [1:0] ALSU_GRP_LOGIC = 2'b01;
    localparam logic [1:0] ALSU_GRP_SHR   = 2'b10;
    localparam logic [1:0] ALSU_GRP_SHL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Only arithmetic ops produce a carry the sequencer keeps in E.
    function automatic logic is_arith(input logic [3:0] sel);
        return sel[3:2] == ALSU_GRP_ARITH;
    endfunction

endpackage

// File: rtl/alsu_acc_ctrl.sv
// Sequencer control: command/response handshake FSM and repeat counter.
//
// state | meaning
// IDLE  | ready for a command
// EXEC  | applying the ALSU result to AC once per cycle, counting down
// DONE  | response presented, waiting for rsp_ready
module alsu_acc_ctrl
    import alsu_pkg::*;
#(
    parameter int CNT_W = ALSU_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic             cmd_load,
    input  logic [CNT_W-1:0] cmd_rep,
    input  logic             arith,
    input  logic             rsp_ready,
    output logic             cmd_ready,
    output logic             rsp_valid,
    output logic             accept,
    output logic             load_we,
    output logic             ac_we,
    output logic             e_we
);

    state_t           state;
    logic [CNT_W-1:0] iter;

    // Strobes decoded from the current state; the datapath registers them.
    assign cmd_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == DONE);
    assign accept    = cmd_valid && cmd_ready;
    assign load_we   = accept && cmd_load;
    assign ac_we     = (state == EXEC);
    assign e_we      = ac_we && arith;

    // Handshake FSM with down-counting iteration register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            iter  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        iter  <= cmd_rep;
                        state <= cmd_load ? DONE : EXEC;
                    end
                end
                EXEC: begin
                    if (iter == '0) begin
                        state <= DONE;
                    end else begin
                        iter <= iter - 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alsu_acc_sequencer.sv
// Accumulator/sequencer around an external combinational 4-bit ALSU.
// Holds AC, E and the latched operation; repeats the op cmd_rep+1 times.
// Define ALSU_ACC_ZFLAG_EN to add the registered rsp_z zero flag.
module alsu_acc_sequencer
    import alsu_pkg::*;
#(
    parameter int WIDTH = ALSU_WIDTH_DEF,
    parameter int CNT_W = ALSU_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_sel,
    input  logic             cmd_cin,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [CNT_W-1:0] cmd_rep,
    input  logic             cmd_load,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_ac,
    output logic             rsp_e,
`ifdef ALSU_ACC_ZFLAG_EN
    output logic             rsp_z,
`endif
    output logic [WIDTH-1:0] alsu_a,
    output logic [WIDTH-1:0] alsu_b,
    output logic [3:0]       alsu_s,
    output logic             alsu_cin,
    input  logic [WIDTH-1:0] alsu_f,
    input  logic             alsu_carry
);

    logic [WIDTH-1:0] ac;
    logic             e;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       sel_q;
    logic             cin_q;
    logic             accept;
    logic             load_we;
    logic             ac_we;
    logic             e_we;

    alsu_acc_ctrl #(
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_load  (cmd_load),
        .cmd_rep   (cmd_rep),
        .arith     (is_arith(sel_q)),
        .rsp_ready (rsp_ready),
        .cmd_ready (cmd_ready),
        .rsp_valid (rsp_valid),
        .accept    (accept),
        .load_we   (load_we),
        .ac_we     (ac_we),
        .e_we      (e_we)
    );

    // Latch the operation on accept so the ALSU lines never follow cmd_* directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q   <= '0;
            sel_q <= '0;
            cin_q <= 1'b0;
        end else if (accept) begin
            b_q   <= cmd_b;
            sel_q <= cmd_sel;
            cin_q <= cmd_cin;
        end
    end

    // Accumulator and carry flag: loaded directly or written back from the ALSU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ac <= '0;
            e  <= 1'b0;
        end else begin
            if (load_we) begin
                ac <= cmd_b;
            end else if (ac_we) begin
                ac <= alsu_f;
            end
            if (e_we) begin
                e <= alsu_carry;
            end
        end
    end

`ifdef ALSU_ACC_ZFLAG_EN
    logic z;

    // Zero flag tracks every AC write, so it is valid alongside rsp_ac.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z <= 1'b1;
        end else if (load_we) begin
            z <= (cmd_b == '0);
        end else if (ac_we) begin
            z <= (alsu_f == '0);
        end
    end

    assign rsp_z = z;
`endif

    assign rsp_ac   = ac;
    assign rsp_e    = e;
    assign alsu_a   = ac;
    assign alsu_b   = b_q;
    assign alsu_s   = sel_q;
    assign alsu_cin = cin_q;

endmodule

// File: tb/tb_alsu_acc_sequencer.sv
// Directed, table-driven bench for alsu_acc_sequencer with a behavioural ALSU.
module tb_alsu_acc_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_sel;
    logic       cmd_cin;
    logic [3:0] cmd_b;
    logic [2:0] cmd_rep;
    logic       cmd_load;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_ac;
    logic       rsp_e;
`ifdef ALSU_ACC_ZFLAG_EN
    logic       rsp_z;
`endif
    logic [3:0] alsu_a;
    logic [3:0] alsu_b;
    logic [3:0] alsu_s;
    logic       alsu_cin;
    logic [3:0] alsu_f;
    logic       alsu_carry;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alsu_acc_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_sel    (cmd_sel),
        .cmd_cin    (cmd_cin),
        .cmd_b      (cmd_b),
        .cmd_rep    (cmd_rep),
        .cmd_load   (cmd_load),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_ac     (rsp_ac),
        .rsp_e      (rsp_e),
`ifdef ALSU_ACC_ZFLAG_EN
        .rsp_z      (rsp_z),
`endif
        .alsu_a     (alsu_a),
        .alsu_b     (alsu_b),
        .alsu_s     (alsu_s),
        .alsu_cin   (alsu_cin),
        .alsu_f     (alsu_f),
        .alsu_carry (alsu_carry)
    );

    // Behavioural ALSU; shifts report the shifted-out bit as carry so a
    // wrongly enabled E write becomes visible.
    logic [3:0] opnd;
    logic [4:0] sum;
    always_comb begin
        opnd       = 4'h0;
        sum        = 5'h0;
        alsu_f     = 4'h0;
        alsu_carry = 1'b0;
        case (alsu_s[3:2])
            2'b00: begin
                case (alsu_s[1:0])
                    2'b00:   opnd = alsu_a;
                    2'b01:   opnd = ~alsu_a;
                    2'b10:   opnd = 4'h0;
                    default: opnd = 4'hF;
                endcase
                sum        = {1'b0, alsu_b} + {1'b0, opnd} + {4'h0, alsu_cin};
                alsu_f     = sum[3:0];
                alsu_carry = sum[4];
            end
            2'b01: begin
                case (alsu_s[1:0])
                    2'b00:   alsu_f = alsu_a & alsu_b;
                    2'b10:   alsu_f = alsu_a | alsu_b;
                    2'b01:   alsu_f = alsu_a ^ alsu_b;
                    default: alsu_f = ~alsu_a;
                endcase
            end
            2'b10: begin
                alsu_f     = {1'b0, alsu_a[3:1]};
                alsu_carry = alsu_a[0];
            end
            default: begin
                alsu_f     = {alsu_a[2:0], 1'b0};
                alsu_carry = alsu_a[3];
            end
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       ld;
        logic [3:0] sel;
        logic       cin;
        logic [3:0] b;
        logic [2:0] rep;
        logic [3:0] mid;
        logic [3:0] ac;
        logic       e;
    } vec_t;

    vec_t tbl[16];

    task automatic do_cmd(input vec_t v, input int idx);
        int n;
        int lat;
        int exp_lat;
        @(negedge clk);
        cmd_load  = v.ld;
        cmd_sel   = v.sel;
        cmd_cin   = v.cin;
        cmd_b     = v.b;
        cmd_rep   = v.rep;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check($sformatf("v%0d accept timeout", idx), 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            if (lat == 2 && v.rep != 3'd0)
                check($sformatf("v%0d mid ac", idx), int'(rsp_ac), int'(v.mid));
            @(negedge clk);
            lat++;
        end
        exp_lat = v.ld ? 1 : int'(v.rep) + 2;
        check($sformatf("v%0d latency", idx), lat, exp_lat);
        check($sformatf("v%0d rsp_ac", idx), int'(rsp_ac), int'(v.ac));
        check($sformatf("v%0d rsp_e", idx), int'(rsp_e), int'(v.e));
`ifdef ALSU_ACC_ZFLAG_EN
        check($sformatf("v%0d rsp_z", idx), int'(rsp_z), int'(v.ac == 4'h0));
`endif
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check($sformatf("v%0d back to idle", idx), int'({rsp_valid, cmd_ready}), 1);
    endtask

    initial begin
        //            ld   sel     cin   b       rep   mid     ac      e
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0101, 3'd0, 4'h0,   4'b0101, 1'b0};
        tbl[1]  = '{1'b0, 4'b0000, 1'b0, 4'b0011, 3'd1, 4'b1000, 4'b1011, 1'b0};
        tbl[2]  = '{1'b1, 4'b0000, 1'b0, 4'b1111, 3'd0, 4'h0,   4'b1111, 1'b0};
        tbl[3]  = '{1'b0, 4'b0000, 1'b0, 4'b0001, 3'd0, 4'h0,   4'b0000, 1'b1};
        tbl[4]  = '{1'b0, 4'b0100, 1'b0, 4'b1010, 3'd0, 4'h0,   4'b0000, 1'b1};
        tbl[5]  = '{1'b1, 4'b0000, 1'b0, 4'b0101, 3'd0, 4'h0,   4'b0101, 1'b1};
        tbl[6]  = '{1'b0, 4'b1100, 1'b0, 4'b0000, 3'd2, 4'b1010, 4'b1000, 1'b1};
        tbl[7]  = '{1'b0, 4'b1000, 1'b0, 4'b0000, 3'd3, 4'b0100, 4'b0000, 1'b1};
        tbl[8]  = '{1'b0, 4'b0010, 1'b1, 4'b0111, 3'd0, 4'h0,   4'b1000, 1'b0};
        tbl[9]  = '{1'b0, 4'b0011, 1'b0, 4'b0010, 3'd0, 4'h0,   4'b0001, 1'b1};
        tbl[10] = '{1'b0, 4'b0101, 1'b0, 4'b1100, 3'd0, 4'h0,   4'b1101, 1'b1};
        tbl[11] = '{1'b0, 4'b0110, 1'b0, 4'b0010, 3'd0, 4'h0,   4'b1111, 1'b1};
        tbl[12] = '{1'b0, 4'b0111, 1'b0, 4'b0000, 3'd0, 4'h0,   4'b0000, 1'b1};
        tbl[13] = '{1'b0, 4'b0001, 1'b1, 4'b1001, 3'd0, 4'h0,   4'b1001, 1'b1};
        tbl[14] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 3'd0, 4'h0,   4'b0000, 1'b1};
        tbl[15] = '{1'b0, 4'b0000, 1'b0, 4'b0011, 3'd7, 4'b0011, 4'b1000, 1'b0};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_sel   = 4'h0;
        cmd_cin   = 1'b0;
        cmd_b     = 4'h0;
        cmd_rep   = 3'd0;
        cmd_load  = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset cmd_ready low", int'(cmd_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check("reset ac", int'(rsp_ac), 0);
        check("reset e", int'(rsp_e), 0);
        check("reset rsp_valid", int'(rsp_valid), 0);
        check("reset cmd_ready", int'(cmd_ready), 1);
        check("reset alsu lines", int'({alsu_a, alsu_b, alsu_s, alsu_cin}), 0);
`ifdef ALSU_ACC_ZFLAG_EN
        check("reset z", int'(rsp_z), 1);
`endif

        for (int i = 0; i < 16; i++) do_cmd(tbl[i], i);

        // Backpressure: response held while the next command waits.
        begin
            vec_t v;
            v = '{1'b1, 4'b0000, 1'b0, 4'b0110, 3'd0, 4'h0, 4'b0110, 1'b0};
            @(negedge clk);
            cmd_load = v.ld; cmd_b = v.b; cmd_sel = v.sel; cmd_rep = v.rep; cmd_cin = v.cin;
            cmd_valid = 1'b1;
            @(negedge clk);
            check("bp load valid", int'(rsp_valid), 1);
            cmd_b = 4'b1001;
            for (int k = 0; k < 5; k++) begin
                check($sformatf("bp hold ac %0d", k), int'(rsp_ac), 6);
                check($sformatf("bp ready low %0d", k), int'(cmd_ready), 0);
                @(negedge clk);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check("bp idle after ready", int'({rsp_valid, cmd_ready}), 1);
            check("bp ac before accept", int'(rsp_ac), 6);
            @(negedge clk);
            cmd_valid = 1'b0;
            check("bp second accepted", int'(rsp_valid), 1);
            check("bp second ac", int'(rsp_ac), 9);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end

        // Set E=1 (1001+1111+1 carries), then reset in the middle of a long shift.
        do_cmd('{1'b0, 4'b0000, 1'b1, 4'b1111, 3'd0, 4'h0, 4'b1001, 1'b1}, 100);
        @(negedge clk);
        cmd_load = 1'b0; cmd_sel = 4'b1100; cmd_rep = 3'd7; cmd_b = 4'h0; cmd_cin = 1'b0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid-exec busy", int'(cmd_ready), 0);
        rst = 1'b1;
        #1;
        check("rst ac", int'(rsp_ac), 0);
        check("rst e", int'(rsp_e), 0);
        check("rst alsu_s", int'(alsu_s), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post-rst cmd_ready", int'(cmd_ready), 1);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 12; k++) begin
                if (rsp_valid) seen = 1;
                @(negedge clk);
            end
            check("no rsp after abort", seen, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
